// File: rtl/debug_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_pkg : shared constants and AR FSM encoding for the hart fan-out stage
// rev 1.0
// ---------------------------------------------------------------------------
package debug_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;

   localparam logic [1:0] ERR_OK        = 2'd0;
   localparam logic [1:0] ERR_NOTHALTED = 2'd1;
   localparam logic [1:0] ERR_NONEXIST  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } ar_state_t;

endpackage
`default_nettype wire

// File: rtl/debug_resume_track.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_resume_track : one hart's pending-resume and sticky resume-ack flags
// rev 1.0
// ---------------------------------------------------------------------------
module debug_resume_track
   import debug_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic set_req,
   input  logic ack_in,
   input  logic clear,
   output logic pend,
   output logic ack
);

   // Hart reset wins over a new resume, which wins over a completing one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 1'b0;
         ack  <= 1'b0;
      end else if (clear) begin
         pend <= 1'b0;
         ack  <= 1'b0;
      end else if (set_req) begin
         pend <= 1'b1;
         ack  <= 1'b0;
      end else if (ack_in && pend) begin
         pend <= 1'b0;
         ack  <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/debug_hart_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_hart_mux : fans the debug control/status and AR path out to NUM_HARTS
// rev 1.0
// ---------------------------------------------------------------------------
module debug_hart_mux
   import debug_pkg::*;
#(
   parameter int NUM_HARTS  = 4,
   parameter int HSW        = 4,
   parameter int AR_TIMEOUT = 255
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic [HSW-1:0]                HARTSEL,
   input  logic                          HALTREQ_I,
   input  logic                          RESUMEREQ_I,
   input  logic                          HARTRESET_I,
   output logic                          HALTED_O,
   output logic                          RUNNING_O,
   output logic                          RESUMEACK_O,
   output logic                          NONEXIST_O,
   output logic                          ANYHALTED_O,
   output logic                          ALLHALTED_O,
   input  logic                          AR_REQ,
   input  logic                          AR_WR,
   input  logic [ADDR_W-1:0]             AR_AD,
   input  logic [DATA_W-1:0]             AR_WDATA,
   output logic                          AR_BUSY,
   output logic                          AR_DONE,
   output logic [DATA_W-1:0]             AR_RDATA,
   output logic [1:0]                    AR_ERR,
   output logic [NUM_HARTS-1:0]          HALTREQ_O,
   output logic [NUM_HARTS-1:0]          RESUMEREQ_O,
   output logic [NUM_HARTS-1:0]          HARTRESET_O,
   input  logic [NUM_HARTS-1:0]          HALTED_I,
   input  logic [NUM_HARTS-1:0]          RUNNING_I,
   input  logic [NUM_HARTS-1:0]          RESUMEACK_I,
   output logic [NUM_HARTS-1:0]          HART_AR_EN,
   output logic                          HART_AR_WR,
   output logic [ADDR_W-1:0]             HART_AR_AD,
   output logic [DATA_W-1:0]             HART_AR_WDATA,
   input  logic [DATA_W*NUM_HARTS-1:0]   HART_AR_RDATA,
   input  logic [NUM_HARTS-1:0]          HART_AR_ACK
);

   logic [NUM_HARTS-1:0] sel_hit, ar_hit, pend, ack, halt_q, reset_q;
   logic                 resume_q, resume_rise;
   ar_state_t            state, state_d;
   logic [HSW-1:0]       ar_sel;
   logic                 ar_wr;
   logic [ADDR_W-1:0]    ar_ad;
   logic [DATA_W-1:0]    ar_wdata, rdata_q, hart_rdata;
   logic [15:0]          timer;
   logic [1:0]           err_q, err_d;
   logic                 hart_ack, hart_halted, ar_exist, load_req, capture;

   assign resume_rise = RESUMEREQ_I & ~resume_q;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      assign sel_hit[h] = (HARTSEL == HSW'(h));
      assign ar_hit[h]  = (ar_sel == HSW'(h));

      debug_resume_track u_track (
         .clk     (CLK),
         .rst_n   (RST_N),
         .set_req (resume_rise & sel_hit[h] & ~HALTREQ_I),
         .ack_in  (RESUMEACK_I[h]),
         .clear   (HARTRESET_I & sel_hit[h]),
         .pend    (pend[h]),
         .ack     (ack[h])
      );
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         halt_q   <= '0;
         reset_q  <= '0;
         resume_q <= 1'b0;
      end else begin
         halt_q   <= HALTREQ_I   ? sel_hit : '0;
         reset_q  <= HARTRESET_I ? sel_hit : '0;
         resume_q <= RESUMEREQ_I;
      end
   end

   // A nonexistent HARTSEL matches no hart, so every status mux reads 0.
   assign HALTED_O    = |(HALTED_I & sel_hit);
   assign RUNNING_O   = |(RUNNING_I & sel_hit);
   assign RESUMEACK_O = |(ack & sel_hit);
   assign NONEXIST_O  = ~|sel_hit;
   assign ANYHALTED_O = |HALTED_I;
   assign ALLHALTED_O = &HALTED_I;
   assign HALTREQ_O   = halt_q;
   assign HARTRESET_O = reset_q;
   assign RESUMEREQ_O = pend;

   assign ar_exist    = |ar_hit;
   assign hart_halted = |(HALTED_I & ar_hit);
   assign hart_ack    = |(HART_AR_ACK & ar_hit);

   always_comb begin
      hart_rdata = '0;
      for (int h = 0; h < NUM_HARTS; h++)
         if (ar_hit[h]) hart_rdata = HART_AR_RDATA[h*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d  = state;
      err_d    = err_q;
      load_req = 1'b0;
      capture  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (AR_REQ) begin
               state_d  = ST_CHECK;
               load_req = 1'b1;
            end
         end
         ST_CHECK: begin
            if (!ar_exist) begin
               state_d = ST_DONE;
               err_d   = ERR_NONEXIST;
            end else if (!hart_halted) begin
               state_d = ST_DONE;
               err_d   = ERR_NOTHALTED;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Ack is tested before expiry so a last-cycle ack still succeeds.
            if (hart_ack) begin
               state_d = ST_DONE;
               err_d   = ERR_OK;
               capture = ~ar_wr;
            end else if (timer == 16'd1) begin
               state_d = ST_DONE;
               err_d   = ERR_TIMEOUT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ar_sel   <= '0;
         ar_wr    <= 1'b0;
         ar_ad    <= '0;
         ar_wdata <= '0;
         timer    <= '0;
         err_q    <= ERR_OK;
         rdata_q  <= '0;
      end else begin
         if (load_req) begin
            ar_sel   <= HARTSEL;
            ar_wr    <= AR_WR;
            ar_ad    <= AR_AD;
            ar_wdata <= AR_WDATA;
         end
         if (state == ST_CHECK)     timer <= 16'(AR_TIMEOUT);
         else if (state == ST_WAIT) timer <= timer - 16'd1;
         err_q <= err_d;
         if (capture) rdata_q <= hart_rdata;
      end
   end

   assign AR_BUSY       = (state == ST_CHECK) || (state == ST_WAIT);
   assign AR_DONE       = (state == ST_DONE);
   assign AR_ERR        = err_q;
   assign AR_RDATA      = rdata_q;
   assign HART_AR_EN    = (state == ST_WAIT) ? ar_hit : '0;
   assign HART_AR_WR    = ar_wr;
   assign HART_AR_AD    = ar_ad;
   assign HART_AR_WDATA = ar_wdata;

endmodule
`default_nettype wire

// File: tb/tb_debug_hart_mux.sv
`default_nettype none
// tb_debug_hart_mux : directed stimulus, age-based reference model, per-cycle compare.
module tb_debug_hart_mux;
   localparam int N   = 4;
   localparam int HSW = 4;
   localparam int TMO = 8;

   logic            CLK = 1'b0, RST_N = 1'b0;
   logic [HSW-1:0]  HARTSEL = '0;
   logic            HALTREQ_I = 0, RESUMEREQ_I = 0, HARTRESET_I = 0;
   logic            HALTED_O, RUNNING_O, RESUMEACK_O, NONEXIST_O, ANYHALTED_O, ALLHALTED_O;
   logic            AR_REQ = 0, AR_WR = 0;
   logic [15:0]     AR_AD = '0;
   logic [31:0]     AR_WDATA = '0;
   logic            AR_BUSY, AR_DONE;
   logic [31:0]     AR_RDATA;
   logic [1:0]      AR_ERR;
   logic [N-1:0]    HALTREQ_O, RESUMEREQ_O, HARTRESET_O, HART_AR_EN;
   logic [N-1:0]    HALTED_I = '0, RUNNING_I = '0, RESUMEACK_I = '0, HART_AR_ACK = '0;
   logic            HART_AR_WR;
   logic [15:0]     HART_AR_AD;
   logic [31:0]     HART_AR_WDATA;
   logic [32*N-1:0] HART_AR_RDATA = '0;

   always #5 CLK = ~CLK;

   debug_hart_mux #(.NUM_HARTS(N), .HSW(HSW), .AR_TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST_N(RST_N), .HARTSEL(HARTSEL), .HALTREQ_I(HALTREQ_I),
      .RESUMEREQ_I(RESUMEREQ_I), .HARTRESET_I(HARTRESET_I), .HALTED_O(HALTED_O),
      .RUNNING_O(RUNNING_O), .RESUMEACK_O(RESUMEACK_O), .NONEXIST_O(NONEXIST_O),
      .ANYHALTED_O(ANYHALTED_O), .ALLHALTED_O(ALLHALTED_O), .AR_REQ(AR_REQ),
      .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_WDATA(AR_WDATA), .AR_BUSY(AR_BUSY),
      .AR_DONE(AR_DONE), .AR_RDATA(AR_RDATA), .AR_ERR(AR_ERR), .HALTREQ_O(HALTREQ_O),
      .RESUMEREQ_O(RESUMEREQ_O), .HARTRESET_O(HARTRESET_O), .HALTED_I(HALTED_I),
      .RUNNING_I(RUNNING_I), .RESUMEACK_I(RESUMEACK_I), .HART_AR_EN(HART_AR_EN),
      .HART_AR_WR(HART_AR_WR), .HART_AR_AD(HART_AR_AD), .HART_AR_WDATA(HART_AR_WDATA),
      .HART_AR_RDATA(HART_AR_RDATA), .HART_AR_ACK(HART_AR_ACK)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: per-hart flags plus an access described by its age in cycles.
   logic [N-1:0] m_halt = '0, m_reset = '0, m_pend = '0, m_ack = '0;
   bit           m_prev_res = 0;
   bit           m_active = 0;
   int           m_age = 0, m_end = 0, m_sel = 0, ms = 0;
   bit           m_wr = 0;
   logic [15:0]  m_ad = '0;
   logic [31:0]  m_wdata = '0, m_rdata = '0;
   logic [1:0]   m_err = '0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_halt = '0; m_reset = '0; m_pend = '0; m_ack = '0; m_prev_res = 0;
         m_active = 0; m_age = 0; m_end = 0; m_err = '0; m_rdata = '0;
      end else begin
         ms = int'(HARTSEL);
         for (int h = 0; h < N; h++) begin
            m_halt[h]  = HALTREQ_I && (ms == h);
            m_reset[h] = HARTRESET_I && (ms == h);
            if (HARTRESET_I && ms == h) begin
               m_pend[h] = 0; m_ack[h] = 0;
            end else if (RESUMEREQ_I && !m_prev_res && !HALTREQ_I && ms == h) begin
               m_pend[h] = 1; m_ack[h] = 0;
            end else if (RESUMEACK_I[h] && m_pend[h]) begin
               m_pend[h] = 0; m_ack[h] = 1;
            end
         end
         m_prev_res = RESUMEREQ_I;

         if (!m_active) begin
            if (AR_REQ) begin
               m_active = 1; m_age = 1; m_end = 0;
               m_sel = ms; m_wr = AR_WR; m_ad = AR_AD; m_wdata = AR_WDATA;
            end
         end else if (m_age == m_end) begin
            m_active = 0;
         end else begin
            if (m_age == 1) begin
               if (m_sel >= N)              begin m_err = 2'd2; m_end = 2; end
               else if (!HALTED_I[m_sel])   begin m_err = 2'd1; m_end = 2; end
            end else if (HART_AR_ACK[m_sel]) begin
               m_err = 2'd0; m_end = m_age + 1;
               if (!m_wr) m_rdata = HART_AR_RDATA[32*m_sel +: 32];
            end else if (m_age == 1 + TMO) begin
               m_err = 2'd3; m_end = m_age + 1;
            end
            m_age++;
         end
      end
   end

   always @(negedge CLK) begin
      int es;
      logic [N-1:0] en_e;
      es = int'(HARTSEL);
      en_e = '0;
      if (m_active && m_end == 0 && m_age >= 2) en_e[m_sel] = 1'b1;
      chk("haltreq_o", HALTREQ_O, m_halt);
      chk("hartreset_o", HARTRESET_O, m_reset);
      chk("resumereq_o", RESUMEREQ_O, m_pend);
      chk("nonexist_o", NONEXIST_O, es >= N);
      chk("anyhalted_o", ANYHALTED_O, HALTED_I != 0);
      chk("allhalted_o", ALLHALTED_O, HALTED_I == {N{1'b1}});
      if (es < N) begin
         chk("halted_o", HALTED_O, HALTED_I[es]);
         chk("running_o", RUNNING_O, RUNNING_I[es]);
         chk("resumeack_o", RESUMEACK_O, m_ack[es]);
      end else begin
         chk("halted_o_nx", HALTED_O, 0);
         chk("running_o_nx", RUNNING_O, 0);
         chk("resumeack_o_nx", RESUMEACK_O, 0);
      end
      chk("ar_busy", AR_BUSY, m_active && m_age != m_end);
      chk("ar_done", AR_DONE, m_active && m_age == m_end);
      chk("hart_ar_en", HART_AR_EN, en_e);
      chk("ar_err", AR_ERR, m_err);
      chk("ar_rdata", AR_RDATA, m_rdata);
      if (en_e != 0) begin
         chk("hart_ar_wr", HART_AR_WR, m_wr);
         chk("hart_ar_ad", HART_AR_AD, m_ad);
         chk("hart_ar_wdata", HART_AR_WDATA, m_wdata);
      end
   end

   // One AR access; ack from the selected hart at age ack_age (0 = never),
   // a stray ack from every other hart at age 3. Returns REQ-to-DONE latency.
   task automatic ar_access(input logic [HSW-1:0] sel, input bit wr, input logic [15:0] ad,
                            input logic [31:0] wd, input int ack_age,
                            input logic [HSW-1:0] sel_after, output int lat);
      logic [N-1:0] oh;
      oh = '0;
      if (int'(sel) < N) oh[int'(sel)] = 1'b1;
      HARTSEL = sel; AR_REQ = 1; AR_WR = wr; AR_AD = ad; AR_WDATA = wd;
      tick();
      AR_REQ = 0; HARTSEL = sel_after; lat = 1;
      while (AR_DONE !== 1'b1 && lat < 40) begin
         HART_AR_ACK = (lat == ack_age) ? oh : ((lat == 3) ? ~oh : '0);
         tick();
         lat++;
      end
      HART_AR_ACK = '0;
      chk("ar_done_seen", AR_DONE, 1);
      tick();
   endtask

   int lat;

   initial begin
      repeat (2) tick();
      chk("rst_haltreq", HALTREQ_O, 0);
      chk("rst_busy", AR_BUSY, 0);
      chk("rst_done", AR_DONE, 0);
      chk("rst_err", AR_ERR, 0);
      chk("rst_rdata", AR_RDATA, 0);
      chk("rst_en", HART_AR_EN, 0);
      RST_N = 1;
      tick();

      HARTSEL = 2; HALTREQ_I = 1; HALTED_I = 4'b0100; RUNNING_I = 4'b1011;
      tick();
      chk("halt_sel2", HALTREQ_O, 4'b0100);
      chk("halted_sel2", HALTED_O, 1);
      chk("anyhalted", ANYHALTED_O, 1);
      chk("allhalted", ALLHALTED_O, 0);
      HALTREQ_I = 0;
      tick();

      HALTREQ_I = 1; RESUMEREQ_I = 1;
      tick();
      chk("halt_priority", RESUMEREQ_O, 4'b0000);
      HALTREQ_I = 0; RESUMEREQ_I = 0;
      tick();

      HARTSEL = 1; RESUMEREQ_I = 1;
      tick();
      chk("resume_h1", RESUMEREQ_O, 4'b0010);
      RESUMEREQ_I = 0; HARTSEL = 0;
      repeat (2) tick();
      chk("resume_h1_desel", RESUMEREQ_O, 4'b0010);
      RESUMEACK_I = 4'b0010;
      tick();
      chk("resume_h1_acked", RESUMEREQ_O, 4'b0000);
      RESUMEACK_I = '0; HARTSEL = 1;
      #1;
      chk("resumeack_h1", RESUMEACK_O, 1);
      HARTRESET_I = 1;
      tick();
      chk("hartreset_h1", HARTRESET_O, 4'b0010);
      chk("resumeack_cleared", RESUMEACK_O, 0);
      HARTRESET_I = 0;
      tick();

      HARTSEL = 5; HALTREQ_I = 1;
      tick();
      chk("halt_nonexist", HALTREQ_O, 0);
      chk("nonexist", NONEXIST_O, 1);
      HALTREQ_I = 0;

      HALTED_I = 4'b1100;
      HART_AR_RDATA = {32'hDEADBEEF, 32'h22222222, 32'h11111111, 32'h00000000};
      ar_access(3, 0, 16'h1001, 32'h0, 6, 0, lat);
      chk("read_latency", lat, 7);
      chk("read_rdata", AR_RDATA, 32'hDEADBEEF);
      chk("read_err", AR_ERR, 0);

      ar_access(5, 0, 16'h1001, 32'h0, 2, 5, lat);
      chk("nx_latency", lat, 2);
      chk("nx_err", AR_ERR, 2);
      ar_access(0, 0, 16'h1001, 32'h0, 2, 0, lat);
      chk("nothalted_err", AR_ERR, 1);
      chk("nothalted_rdata_held", AR_RDATA, 32'hDEADBEEF);

      ar_access(2, 1, 16'h0300, 32'hCAFEF00D, 2, 2, lat);
      chk("write_min_latency", lat, 3);
      chk("write_err", AR_ERR, 0);
      chk("write_rdata_held", AR_RDATA, 32'hDEADBEEF);

      ar_access(3, 0, 16'h1002, 32'h0, 0, 3, lat);
      chk("timeout_latency", lat, 2 + TMO);
      chk("timeout_err", AR_ERR, 3);
      HART_AR_ACK = 4'b1000;
      repeat (2) tick();
      chk("late_ack_done", AR_DONE, 0);
      chk("late_ack_busy", AR_BUSY, 0);
      chk("late_ack_err", AR_ERR, 3);
      HART_AR_ACK = '0;

      HART_AR_RDATA[127:96] = 32'h13579BDF;
      ar_access(3, 0, 16'h1003, 32'h0, 1 + TMO, 3, lat);
      chk("lastcycle_ack_err", AR_ERR, 0);
      chk("lastcycle_ack_rdata", AR_RDATA, 32'h13579BDF);

      HARTSEL = 0; RESUMEREQ_I = 1;
      tick();
      RESUMEREQ_I = 0; HARTSEL = 3; AR_REQ = 1; AR_WR = 0;
      tick();
      AR_REQ = 0;
      repeat (2) tick();
      chk("pre_reset_en", HART_AR_EN, 4'b1000);
      chk("pre_reset_pend", RESUMEREQ_O, 4'b0001);
      #2 RST_N = 0;
      #1;
      chk("async_en", HART_AR_EN, 0);
      chk("async_busy", AR_BUSY, 0);
      chk("async_pend", RESUMEREQ_O, 0);
      repeat (2) tick();
      RST_N = 1;
      HARTSEL = 0;
      tick();
      chk("post_reset_ack", RESUMEACK_O, 0);
      chk("post_reset_err", AR_ERR, 0);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
